// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, FSM state type and frame-length helper.
// Used by the frame builder, this TX serializer and the future receiver.
// BREAK/MARK states are only reached when UART_TX_BREAK_EN is defined.
package uart_pkg;

  // Widest frame: 8 data + parity + 2 stop bits (start bit not included).
  localparam int unsigned FRAME_W = 11;

  // Serializer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StBreak,
    StMark
  } uart_state_e;

  // Number of bits after the start bit: 7 + d_num + parity + 1 + s_num (8..11).
  function automatic logic [3:0] frame_len(input logic       d_num,
                                           input logic       s_num,
                                           input logic [1:0] par);
    logic [3:0] len;
    len = 4'd8 + {3'b000, d_num} + {3'b000, |par} + {3'b000, s_num};
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Frame handshake and serial-line bundle between the frame builder (master)
// and the TX serializer (slave).
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic [FRAME_W-1:0] frame_in;
  logic               d_num;
  logic               s_num;
  logic [1:0]         par;
  logic               frame_valid;
  logic               frame_ready;
  logic               tx;
  logic               busy;
  logic               tx_done;

  // Frame builder side: offers frames, observes the serializer status.
  modport master (
    output frame_in,
    output d_num,
    output s_num,
    output par,
    output frame_valid,
    input  frame_ready,
    input  tx,
    input  busy,
    input  tx_done
  );

  // Serializer side: consumes frames, drives the line and status.
  modport slave (
    input  frame_in,
    input  d_num,
    input  s_num,
    input  par,
    input  frame_valid,
    output frame_ready,
    output tx,
    output busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// 'clear' restarts the count so a new bit time begins the following cycle.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Terminal count marks the last cycle of the current bit time.
  assign bit_end = (cnt_q == TermCnt);

  // Next count: restart on clear or wrap after the terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches one pre-assembled frame per handshake and
// shifts it out LSB-first after a start bit, CLKS_PER_BIT clocks per bit.
// All outputs are registered; they are computed from the next state.
// Optional feature macro: UART_TX_BREAK_EN adds a break_req input and the
// BREAK/MARK states (hold the line low, then one bit time of mark).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_req,
`endif
  uart_tx_serializer_if.slave  bus
);

  uart_state_e        state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               clear;
  logic               bit_end;

  // Bit-time timer, restarted whenever a new bit time begins out of idle.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bit_end (bit_end)
  );

  // A frame is taken only when advertised ready; a pending break wins.
`ifdef UART_TX_BREAK_EN
  assign accept = bus.frame_valid && ready_q && (state_q == StIdle) && !break_req;
`else
  assign accept = bus.frame_valid && ready_q && (state_q == StIdle);
`endif

  // Next-state, datapath and done-pulse logic.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    done_d   = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_d = StBreak;
        end else
`endif
        if (accept) begin
          state_d  = StStart;
          shreg_d  = bus.frame_in;
          bitcnt_d = frame_len(bus.d_num, bus.s_num, bus.par);
          clear    = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d  = {1'b0, shreg_q[FRAME_W-1:1]};
          bitcnt_d = bitcnt_q - 4'd1;
          // Counter still holds the bit just finished; 1 means it was the last.
          if (bitcnt_q == 4'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        if (!break_req) begin
          state_d = StMark;
          clear   = 1'b1;
        end
      end
      StMark: begin
        if (bit_end) begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs derived from the state being entered.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    unique case (state_d)
      StIdle: begin
        ready_d = 1'b1;
      end
      StStart: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      StData: begin
        tx_d   = shreg_d[0];
        busy_d = 1'b1;
      end
      StBreak: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      StMark: begin
        busy_d = 1'b1;
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.frame_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer with CLKS_PER_BIT = 4.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_uart_tx_serializer;

  localparam int C = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef UART_TX_BREAK_EN
  logic break_req = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  uart_tx_serializer_if bus_if ();

  uart_tx_serializer #(
    .CLKS_PER_BIT (C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef UART_TX_BREAK_EN
    .break_req (break_req),
`endif
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_if.frame_valid = 1'b0;
    bus_if.frame_in = '0;
    bus_if.d_num = 1'b1;
    bus_if.s_num = 1'b0;
    bus_if.par = 2'b00;
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (bus_if.tx !== 1'b1) begin
      errors++; $display("FAIL reset_tx got %b exp 1", bus_if.tx);
    end
    checks++;
    if (bus_if.frame_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", bus_if.frame_ready);
    end
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.tx_done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done got %b%b exp 00", bus_if.busy, bus_if.tx_done);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus_if.frame_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1", bus_if.frame_ready);
    end
  endtask

  task automatic test_8n1();
    logic [9:0] exp = 10'b1101001010;  // 0xA5: start, 1,0,1,0,0,1,0,1, stop
    bus_if.frame_in = 11'b0_01_10100101;
    bus_if.d_num = 1'b1; bus_if.s_num = 1'b0; bus_if.par = 2'b00;
    bus_if.frame_valid = 1'b1;
    step();
    bus_if.frame_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (bus_if.tx !== exp[c/C]) begin
        errors++; $display("FAIL 8n1_tx cycle %0d got %b exp %b", c, bus_if.tx, exp[c/C]);
      end
      checks++;
      if (bus_if.busy !== 1'b1 || bus_if.tx_done !== 1'b0 || bus_if.frame_ready !== 1'b0) begin
        errors++; $display("FAIL 8n1_status cycle %0d got busy %b done %b ready %b exp 1 0 0",
                           c, bus_if.busy, bus_if.tx_done, bus_if.frame_ready);
      end
      step();
    end
    checks++;
    if (bus_if.tx_done !== 1'b1 || bus_if.frame_ready !== 1'b1 || bus_if.tx !== 1'b1) begin
      errors++; $display("FAIL 8n1_done got done %b ready %b tx %b exp 1 1 1",
                         bus_if.tx_done, bus_if.frame_ready, bus_if.tx);
    end
    step();
    checks++;
    if (bus_if.tx_done !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL 8n1_done_pulse got done %b busy %b exp 0 0",
                         bus_if.tx_done, bus_if.busy);
    end
  endtask

  task automatic test_7e2();
    logic [10:0] exp = 11'b11010000010;  // start, 1000001 LSB-first, parity 0, 2 stops
    int busy_cycles = 0;
    bus_if.frame_in = 11'b0_11_0_1000001;
    bus_if.d_num = 1'b0; bus_if.s_num = 1'b1; bus_if.par = 2'b01;
    bus_if.frame_valid = 1'b1;
    step();
    bus_if.frame_valid = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (bus_if.tx !== exp[c/C]) begin
        errors++; $display("FAIL 7e2_tx cycle %0d got %b exp %b", c, bus_if.tx, exp[c/C]);
      end
      if (bus_if.busy === 1'b1) busy_cycles++;
      step();
    end
    checks++;
    if (busy_cycles != 44 || bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL 7e2_busy got %0d cycles (now %b) exp 44 (now 0)",
                         busy_cycles, bus_if.busy);
    end
    checks++;
    if (bus_if.tx_done !== 1'b1) begin
      errors++; $display("FAIL 7e2_done got %b exp 1", bus_if.tx_done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_a = 10'b1010101010;  // 0x55
    logic [9:0] exp_b = 10'b1000011110;  // 0x0F
    logic       e;
    int         dones = 0;
    bus_if.d_num = 1'b1; bus_if.s_num = 1'b0; bus_if.par = 2'b00;
    bus_if.frame_in = 11'b0_01_01010101;
    bus_if.frame_valid = 1'b1;
    step();
    bus_if.frame_in = 11'b0_01_00001111;
    for (int c = 0; c < 81; c++) begin
      if (c < 40) e = exp_a[c/C];
      else if (c == 40) e = 1'b1;
      else e = exp_b[(c-41)/C];
      if (c == 41) bus_if.frame_valid = 1'b0;
      checks++;
      if (bus_if.tx !== e) begin
        errors++; $display("FAIL b2b_tx cycle %0d got %b exp %b", c, bus_if.tx, e);
      end
      if (bus_if.tx_done === 1'b1) dones++;
      if (c == 40) begin
        checks++;
        if (bus_if.tx_done !== 1'b1 || bus_if.frame_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_gap got done %b ready %b exp 1 1",
                             bus_if.tx_done, bus_if.frame_ready);
        end
      end
      step();
    end
    if (bus_if.tx_done === 1'b1) dones++;
    repeat (8) begin
      step();
      if (bus_if.tx_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 2) begin
      errors++; $display("FAIL b2b_done_count got %0d exp 2", dones);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [9:0] exp = 10'b1101001010;  // 0xA5
    int dones = 0;
    bus_if.d_num = 1'b1; bus_if.s_num = 1'b0; bus_if.par = 2'b00;
    bus_if.frame_in = 11'b0_01_10100101;
    bus_if.frame_valid = 1'b1;
    step();
    bus_if.frame_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c == 10) begin
        bus_if.frame_in = 11'b0_01_00000000;
        bus_if.frame_valid = 1'b1;
      end
      if (c == 11) bus_if.frame_valid = 1'b0;
      if (c < 40) begin
        checks++;
        if (bus_if.tx !== exp[c/C]) begin
          errors++; $display("FAIL ignore_tx cycle %0d got %b exp %b", c, bus_if.tx, exp[c/C]);
        end
      end
      if (bus_if.tx_done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 1 || bus_if.busy !== 1'b0) begin
      errors++; $display("FAIL ignore_done_count got %0d busy %b exp 1 0", dones, bus_if.busy);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] exp = 10'b1001111000;  // 0x3C
    int dones = 0;
    bus_if.d_num = 1'b1; bus_if.s_num = 1'b0; bus_if.par = 2'b00;
    bus_if.frame_in = 11'b0_01_10100101;
    bus_if.frame_valid = 1'b1;
    step();
    bus_if.frame_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    checks++;
    if (bus_if.tx !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.frame_ready !== 1'b0 ||
        bus_if.tx_done !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got tx %b busy %b ready %b done %b exp 1 0 0 0",
                         bus_if.tx, bus_if.busy, bus_if.frame_ready, bus_if.tx_done);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus_if.frame_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready got %b exp 1", bus_if.frame_ready);
    end
    for (int c = 0; c < 40; c++) begin
      if (bus_if.tx_done === 1'b1 || bus_if.tx !== 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL midreset_quiet got %0d active cycles exp 0", dones);
    end
    bus_if.frame_in = 11'b0_01_00111100;
    bus_if.frame_valid = 1'b1;
    step();
    bus_if.frame_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (bus_if.tx !== exp[c/C]) begin
        errors++; $display("FAIL midreset_new_tx cycle %0d got %b exp %b", c, bus_if.tx, exp[c/C]);
      end
      step();
    end
    checks++;
    if (bus_if.tx_done !== 1'b1) begin
      errors++; $display("FAIL midreset_new_done got %b exp 1", bus_if.tx_done);
    end
    step();
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    bus_if.frame_valid = 1'b1;  // break must win over a simultaneous frame
    bus_if.frame_in = 11'b0_01_10100101;
    break_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (c == 29) break_req = 1'b0;
      checks++;
      if (bus_if.tx !== 1'b0 || bus_if.frame_ready !== 1'b0) begin
        errors++; $display("FAIL break_low cycle %0d got tx %b ready %b exp 0 0",
                           c, bus_if.tx, bus_if.frame_ready);
      end
    end
    bus_if.frame_valid = 1'b0;
    for (int c = 0; c < C; c++) begin
      step();
      checks++;
      if (bus_if.tx !== 1'b1 || bus_if.frame_ready !== 1'b0) begin
        errors++; $display("FAIL break_mark cycle %0d got tx %b ready %b exp 1 0",
                           c, bus_if.tx, bus_if.frame_ready);
      end
    end
    step();
    checks++;
    if (bus_if.frame_ready !== 1'b1 || bus_if.tx !== 1'b1) begin
      errors++; $display("FAIL break_idle got ready %b tx %b exp 1 1",
                         bus_if.frame_ready, bus_if.tx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    step();
    test_7e2();
    step();
    test_back_to_back();
    step();
    test_ignore_midframe();
    step();
    test_reset_midframe();
    step();
`ifdef UART_TX_BREAK_EN
    test_break();
    step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer: accepts one pre-assembled 11-bit character frame per handshake and drives it onto the serial TX line. Each frame goes out as a start bit, then the frame bits LSB-first, with a fixed number of clocks per bit. It sits directly downstream of the frame builder and consumes its `frame_out` together with the same format controls (`d_num`, `s_num`, `par`). It is the last stage before the TX pad.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per bit time; legal values are 2 and up.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_in`  in  11  frame word:
  - data in bits [6:0] or [7:0];
  - then the optional parity bit;
  - then the stop bit(s);
  - unused MSBs are 0.
- `d_num`  in  1  data length: 1 = 8 data bits, 0 = 7 data bits.
- `s_num`  in  1  stop bits: 1 = 2 stop bits, 0 = 1 stop bit.
- `par`  in  2  parity mode; any nonzero value means a parity bit is present.
- `frame_valid`  in  1  `frame_in` and the format controls are valid.
- `frame_ready`  out  1  block can accept a frame this cycle.
- `tx`  out  1  serial line; idle level is 1.
- `busy`  out  1  a frame is in flight.
- `tx_done`  out  1  one-cycle pulse after the last stop bit completes.

## Operation
- Frame length: `nbits = 7 + d_num + (par != 0) + 1 + s_num`, giving a range of 8..11 bits. The start bit is not counted in `nbits`.
- Handshake: a frame is accepted when `frame_valid && frame_ready`. On accept:
  - `frame_in` is latched into an 11-bit shift register;
  - `nbits` is latched into a 4-bit counter.
- `frame_valid` while `frame_ready=0` is ignored. No buffering.
- FSM states:
  - **IDLE**: `tx=1`, `frame_ready=1`. Accept moves to START.
  - **START**: `tx=0` for `CLKS_PER_BIT` cycles, then moves to DATA.
  - **DATA**: `tx=shreg[0]`. At each bit end:
    - shift right by one and decrement the bit counter;
    - after the `nbits`-th bit, move to IDLE and pulse `tx_done`.
- Stop bits are taken from `frame_in`. The block does not force them to 1; it transmits what it was given.
- `busy=1` in START and DATA.
- Bit timer: counts 0..`CLKS_PER_BIT`-1 and generates `bit_end` at terminal count. It is cleared on accept.
- Reset behaviour, including reset asserted mid-frame:
  - outputs take their reset values the cycle after `reset` is sampled high;
  - the frame in flight is abandoned with no `tx_done`;
  - state returns to IDLE.

## Timing
- Output values while `reset` is asserted: `tx=1`, `frame_ready=0`, `busy=0`, `tx_done=0`.
- `frame_ready` rises the first cycle after `reset` deasserts.
- All outputs are registered.
- Accept in cycle N:
  - `tx` drops to 0 in cycle N+1;
  - bit k (k=0 is the start bit) occupies cycles N+1+k·`CLKS_PER_BIT` .. N+(k+1)·`CLKS_PER_BIT`.
- `tx_done` and `frame_ready` are both 1 in cycle N+1+(1+`nbits`)·`CLKS_PER_BIT`, with `tx=1`.
- Back-to-back: an accept in the `tx_done` cycle starts the next start bit in the following cycle. This leaves exactly one idle clock, not one idle bit time.
- Throughput: one frame per (1+`nbits`)·`CLKS_PER_BIT`+1 cycles.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- Defined:
  - adds input `break_req` (1 bit);
  - in IDLE, `break_req=1` enters state BREAK: `tx=0`, `busy=1`, `frame_ready=0`, held for as long as `break_req=1`;
  - on release, state MARK drives `tx=1` for one full bit time (`CLKS_PER_BIT` cycles), then returns to IDLE;
  - `break_req` arriving during START/DATA is ignored until IDLE;
  - if `frame_valid` and `break_req` are both high in IDLE, break wins.
- Undefined: no `break_req` port, no BREAK/MARK states.

## Structure
- `uart_pkg` contains:
  - `FRAME_W = 11`;
  - the state enum (IDLE, START, DATA, BREAK, MARK);
  - function `frame_len(d_num, s_num, par)` returning 4 bits.
- This package is shared with the frame builder and the future receiver.
- One sub-module, `uart_baud_gen`: parameter `CLKS_PER_BIT`, inputs `clk`, `reset`, `clear`, output `bit_end`.

## Test plan
- 8N1, `CLKS_PER_BIT=4`, `frame_in=11'b0_01_10100101` (0xA5) -> `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `tx_done` 41 cycles after accept.
- 7E2 (`d_num=0`, `s_num=1`, `par=1`), `frame_in=11'b0_11_0_1000001` -> `tx` sequence 0,1,0,0,0,0,0,1,0,1,1; `busy` for 44 cycles.
- Back-to-back: hold `frame_valid=1` with 0x55 then 0x0F, 8N1 -> exactly one `tx=1` clock between the first frame's stop bit and the second frame's start bit; two `tx_done` pulses.
- `frame_valid` pulsed mid-frame with a different word -> ignored; `tx` stream unchanged; only one `tx_done`.
- `reset` asserted at cycle 10 of an 8N1 frame -> next cycle `tx=1`, `busy=0`, `frame_ready=0`, no `tx_done`; a new frame after release transmits correctly.
- `UART_TX_BREAK_EN`: `break_req` high for 30 cycles in IDLE -> `tx=0` for 30 cycles, then `tx=1` for `CLKS_PER_BIT` cycles with `frame_ready=0`, then `frame_ready=1`.
